// File: rtl/vram_term.sv
// 40x24 character frame store: cursor, wrap, hardware scroll, clear; 1-cycle registered VGA read port.
// wr_ready drops for ROWS*COLS cycles on clear/reset and for COLS cycles on a scrolling newline.
module vram_term #(
  parameter int COLS      = 40,
  parameter int ROWS      = 24,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  input  logic [6:0] wr_char,
  output logic       wr_ready,
  input  logic       clr,
  input  logic [5:0] rd_col,
  input  logic [4:0] rd_row,
  output logic [5:0] rd_char,
  output logic       cursor_hit,
  output logic [5:0] cursor_col,
  output logic [4:0] cursor_row
);
  localparam int NCELL = COLS * ROWS;
  localparam int AW    = $clog2(NCELL);
  localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [AW-1:0] LAST_CELL  = AW'(NCELL - 1);
  localparam logic [AW-1:0] LAST_COL_A = AW'(COLS - 1);
  localparam logic [AW-1:0] COLS_A     = AW'(COLS);
  localparam logic [5:0]    LAST_COL   = 6'(COLS - 1);
  localparam logic [4:0]    LAST_ROW   = 5'(ROWS - 1);
  localparam logic [5:0]    ROWS_W     = 6'(ROWS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [5:0]    BLANK      = 6'h20;

  typedef enum logic [1:0] {CLRALL, IDLE, CLRLINE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] sweep, sweep_nxt;
  logic [5:0]    col_nxt;
  logic [4:0]    row_nxt;
  logic [4:0]    top, top_nxt;
  logic [5:0]    mem [NCELL];
  logic          we;
  logic [AW-1:0] waddr;
  logic [5:0]    wdat;
  logic          newline;
  logic          printable;
  logic [5:0]    code;
  logic [AW-1:0] cur_base;
  logic [AW-1:0] rd_addr;
  logic          rd_in;
  logic [BW-1:0] blink_cnt;
  logic          phase;

  // Base address of a logical row once the scroll offset is applied.
  function automatic logic [AW-1:0] row_base(input logic [4:0] row, input logic [4:0] t);
    logic [5:0] sum;
    logic [4:0] prow;
    sum  = {1'b0, row} + {1'b0, t};
    prow = (sum >= ROWS_W) ? 5'(sum - ROWS_W) : sum[4:0];
    return AW'(prow) * COLS_A;
  endfunction

  // Lowercase folds onto uppercase: 0x60-0x7F keep only their low five bits.
  assign code      = wr_char[6] ? {1'b0, wr_char[4:0]} : wr_char[5:0];
  assign printable = (wr_char[6:5] != 2'b00);
  assign cur_base  = row_base(cursor_row, top);
  assign rd_in     = (rd_col <= LAST_COL) && (rd_row <= LAST_ROW);
  assign rd_addr   = row_base(rd_row, top) + AW'(rd_col);

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep;
    col_nxt   = cursor_col;
    row_nxt   = cursor_row;
    top_nxt   = top;
    we        = 1'b0;
    waddr     = cur_base + AW'(cursor_col);
    wdat      = BLANK;
    newline   = 1'b0;
    wr_ready  = (state == IDLE) && !clr;
    unique case (state)
      CLRALL: begin
        we    = 1'b1;
        waddr = sweep;
        if (sweep == LAST_CELL) begin
          sweep_nxt = '0;
          col_nxt   = '0;
          row_nxt   = '0;
          top_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          sweep_nxt = sweep + 1'b1;
        end
      end
      IDLE: begin
        if (clr) begin
          state_nxt = CLRALL;
        end else if (wr_valid) begin
          if (printable) begin
            we   = 1'b1;
            wdat = code;
            if (cursor_col < LAST_COL) col_nxt = cursor_col + 1'b1;
            else                       newline = 1'b1;
          end else if (wr_char == 7'h0D) begin
            newline = 1'b1;
          end
        end
        if (newline) begin
          col_nxt = '0;
          if (cursor_row < LAST_ROW) begin
            row_nxt = cursor_row + 1'b1;
          end else begin
            top_nxt   = (top == LAST_ROW) ? '0 : top + 1'b1;
            state_nxt = CLRLINE;
          end
        end
      end
      CLRLINE: begin
        // Cursor sits on the bottom row, which now maps onto the old top row.
        we    = 1'b1;
        waddr = cur_base + sweep;
        if (sweep == LAST_COL_A) begin
          sweep_nxt = '0;
          state_nxt = IDLE;
        end else begin
          sweep_nxt = sweep + 1'b1;
        end
      end
      default: state_nxt = CLRALL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLRALL;
      sweep      <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      top        <= '0;
    end else begin
      state      <= state_nxt;
      sweep      <= sweep_nxt;
      cursor_col <= col_nxt;
      cursor_row <= row_nxt;
      top        <= top_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_char    <= '0;
      cursor_hit <= 1'b0;
    end else begin
      rd_char    <= rd_in ? mem[rd_addr] : BLANK;
      cursor_hit <= rd_in && (rd_col == cursor_col) && (rd_row == cursor_row) && phase;
    end
  end
endmodule

// File: tb/tb_vram_term.sv
// Bench for vram_term: random character streams against a logical-screen model with row shifting.
module tb_vram_term;
  localparam int COLS = 40;
  localparam int ROWS = 24;
  localparam int BDIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_valid = 1'b0;
  logic [6:0] wr_char = '0;
  logic       wr_ready;
  logic       clr = 1'b0;
  logic [5:0] rd_col = '0;
  logic [4:0] rd_row = '0;
  logic [5:0] rd_char;
  logic       cursor_hit;
  logic [5:0] cursor_col;
  logic [4:0] cursor_row;

  int n_chk = 0;
  int n_pass = 0;
  int edges = 0;
  int scr [ROWS][COLS];
  int cx = 0;
  int cy = 0;

  vram_term #(.COLS(COLS), .ROWS(ROWS), .BLINK_DIV(BDIV)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_char(wr_char), .wr_ready(wr_ready),
    .clr(clr), .rd_col(rd_col), .rd_row(rd_row), .rd_char(rd_char), .cursor_hit(cursor_hit),
    .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Blink phase seen by the read issued before the edge just taken.
  function automatic bit phase_on();
    return (((edges - 1) / BDIV) % 2) == 0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 32;
    cx = 0;
    cy = 0;
  endtask

  task automatic model_put(input int c, output bit scrolled);
    bit nl;
    int v;
    nl = 0;
    scrolled = 0;
    if (c >= 32) begin
      v = (c >= 96) ? c - 32 : c;
      scr[cy][cx] = v % 64;
      if (cx < COLS - 1) cx++;
      else nl = 1;
    end else if (c == 13) begin
      nl = 1;
    end
    if (nl) begin
      cx = 0;
      if (cy < ROWS - 1) begin
        cy++;
      end else begin
        for (int r = 0; r < ROWS - 1; r++)
          for (int k = 0; k < COLS; k++) scr[r][k] = scr[r+1][k];
        for (int k = 0; k < COLS; k++) scr[ROWS-1][k] = 32;
        scrolled = 1;
      end
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wr_ready && n < 3000);
  endtask

  task automatic send(input logic [6:0] c);
    int n;
    bit sc;
    n = 0;
    while (!wr_ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!wr_ready) begin
      chk("send_ready", 0, 1);
      return;
    end
    wr_valid = 1'b1;
    wr_char  = c;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    model_put(int'(c), sc);
    chk("cur_col", cursor_col, cx);
    chk("cur_row", cursor_row, cy);
    if (sc) begin
      wait_ready(n);
      chk("scroll_busy", n, COLS);
    end
  endtask

  task automatic check_screen(input string tag);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        rd_col = 6'(c);
        rd_row = 5'(r);
        @(posedge clk); #1;
        chk({tag, "_chr"}, rd_char, scr[r][c]);
        chk({tag, "_hit"}, cursor_hit, (c == cx && r == cy && phase_on()));
      end
    end
  endtask

  task automatic do_reset(input string tag);
    int n;
    wr_valid = 1'b0;
    clr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_rdy"}, wr_ready, 0);
    chk({tag, "_rst_chr"}, rd_char, 0);
    chk({tag, "_rst_hit"}, cursor_hit, 0);
    chk({tag, "_rst_col"}, cursor_col, 0);
    chk({tag, "_rst_row"}, cursor_row, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    wait_ready(n);
    chk({tag, "_clr_latency"}, n, ROWS * COLS);
  endtask

  function automatic logic [6:0] rnd_print();
    return 7'($urandom_range(32, 127));
  endfunction

  initial begin
    int n;
    int r;
    bit sc;
    #2;
    do_reset("por");
    check_screen("blank");

    // Read of the cell being written returns the old data, new data one cycle later.
    rd_col = 0;
    rd_row = 0;
    wr_valid = 1'b1;
    wr_char = 7'h41;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    model_put(32'h41, sc);
    chk("rd_old", rd_char, 6'h20);
    @(posedge clk); #1;
    chk("rd_new", rd_char, 6'h01);
    send(7'h61);
    rd_col = 1;
    @(posedge clk); #1;
    chk("rd_fold", rd_char, 6'h01);
    chk("a_col", cursor_col, 2);
    chk("a_row", cursor_row, 0);

    repeat (COLS - 2) send(rnd_print());
    chk("wrap_col", cursor_col, 0);
    chk("wrap_row", cursor_row, 1);
    repeat (4) send(rnd_print());
    send(7'h0D);
    send(7'h0D);
    repeat (5) send(rnd_print());
    chk("pre_cr_col", cursor_col, 5);
    chk("pre_cr_row", cursor_row, 3);
    send(7'h0D);
    chk("cr_col", cursor_col, 0);
    chk("cr_row", cursor_row, 4);

    while (cy < ROWS - 1) begin
      repeat (3) send(rnd_print());
      send(7'h0D);
    end
    repeat (2) send(rnd_print());
    send(7'h0D);
    chk("scroll_col", cursor_col, 0);
    chk("scroll_row", cursor_row, ROWS - 1);
    check_screen("scroll");

    repeat (400) begin
      r = $urandom_range(0, 99);
      if (r < 70)      send(rnd_print());
      else if (r < 85) send(7'h0D);
      else             send(7'($urandom_range(0, 31)));
    end
    check_screen("rand");

    // clr wins over a simultaneous character; a second clr while busy is ignored.
    wr_valid = 1'b1;
    wr_char = 7'h5A;
    clr = 1'b1;
    #1;
    chk("clr_rdy_low", wr_ready, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    wr_valid = 1'b0;
    model_clear();
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      clr = (n == 100);
    end while (!wr_ready && n < 3000);
    clr = 1'b0;
    chk("clr_busy", n, ROWS * COLS);
    chk("clr_col", cursor_col, 0);
    chk("clr_row", cursor_row, 0);
    check_screen("clr");

    rd_col = 0;
    rd_row = 0;
    for (int i = 0; i < 4 * BDIV; i++) begin
      @(posedge clk); #1;
      chk("blink", cursor_hit, phase_on());
    end
    rd_col = 6'd40; rd_row = 5'd0;
    @(posedge clk); #1;
    chk("oor_col_chr", rd_char, 6'h20);
    chk("oor_col_hit", cursor_hit, 0);
    rd_col = 6'd0; rd_row = 5'd24;
    @(posedge clk); #1;
    chk("oor_row_chr", rd_char, 6'h20);
    chk("oor_row_hit", cursor_hit, 0);
    rd_col = 6'd63; rd_row = 5'd31;
    @(posedge clk); #1;
    chk("oor_max_chr", rd_char, 6'h20);

    repeat (ROWS - 1) send(7'h0D);
    chk("mid_pre_row", cursor_row, ROWS - 1);
    wr_valid = 1'b1;
    wr_char = 7'h0D;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", wr_ready, 0);
    rd_col = 0;
    rd_row = 0;
    do_reset("mid");
    check_screen("mid");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vram_term.md
# vram_term

Character-terminal frame store that sits directly upstream of the font ROM in the VGA path. It accepts ASCII characters from the CPU/PIA side over a valid/ready handshake and maintains a 40x24 screen buffer, including cursor advance, carriage return, line wrap, hardware scroll and clear-screen. A registered read port, driven by the VGA timing generator's column/row counters, delivers the 6-bit character code consumed by the font ROM, together with a cursor-hit flag for blink overlay.

## Interface
- COLS, 40, characters per row
- ROWS, 24, rows per screen
- BLINK_DIV, 12_500_000, clk cycles per cursor blink half-period (>=1)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  character available
- wr_char  in  7  ASCII code
- wr_ready  out  1  block accepts a character this cycle
- clr  in  1  single-cycle clear-screen request
- rd_col  in  6  VGA character column
- rd_row  in  5  VGA character row
- rd_char  out  6  character code for (rd_col, rd_row), registered
- cursor_hit  out  1  (rd_col, rd_row) is the cursor and blink phase is on, registered with rd_char
- cursor_col  out  6  current cursor column
- cursor_row  out  5  current cursor row (logical)

## Operation
- Storage: COLS*ROWS x 6-bit RAM, not reset. Physical row = (logical row + top) mod ROWS; address = prow*COLS + col.
- Code mapping: wr_char 0x60-0x7F folds to 0x40-0x5F, then code = ascii[5:0]. Space maps to 6'h20.
- States: CLRALL, IDLE, CLRLINE. Reset enters CLRALL.
- wr_ready = (state == IDLE) & ~clr. Transfer occurs when wr_valid & wr_ready.
- IDLE, clr=1: enter CLRALL. clr outranks wr_valid in the same cycle; that character is not accepted.
- CLRALL: write 6'h20 to every address, 0..COLS*ROWS-1, one per cycle. On completion: cursor=(0,0), top=0, then IDLE. clr is ignored while busy.
- Printable characters (0x20-0x7F after fold):
  - Write code at the cursor in the accept cycle.
  - If col<COLS-1: col++.
  - Otherwise perform a newline.
- CR (0x0D): newline, no RAM write. Other codes <0x20 are accepted and ignored.
- Newline:
  - col=0.
  - If row<ROWS-1: row++, stay in IDLE.
  - Else: top=(top+1) mod ROWS, row stays ROWS-1, enter CLRLINE.
- CLRLINE: write 6'h20 across the physical row that just became the bottom (the old top), COLS cycles, then IDLE.
- Read port:
  - rd_char is RAM[(rd_row+top) mod ROWS, rd_col], registered.
  - rd_col>=COLS or rd_row>=ROWS yields 6'h20 and cursor_hit=0.
  - Read and write to the same address in the same cycle returns the old data.
- Blink: counter wraps at BLINK_DIV-1 and toggles the phase bit; phase resets to 1 (on). cursor_hit = (rd_col==cursor_col) & (rd_row==cursor_row) & phase. The comparison is shown as written but must be registered, so that cursor_hit is delivered one cycle after its address, aligned with rd_char.

## Timing
- Reset values:
  - wr_ready=0, rd_char=0, cursor_hit=0, cursor_col=0, cursor_row=0.
  - top=0, phase=1, state=CLRALL, sweep counter=0.
- wr_ready rises COLS*ROWS cycles after reset deassertion (960 at defaults).
- Read latency: exactly 1 cycle from rd_col/rd_row to rd_char/cursor_hit, every cycle, independent of write activity.
- A written character is visible on the read port from the cycle after the accept edge.
- Cursor outputs update on the accept edge.
- Throughput:
  - 1 char/cycle with no scroll.
  - A scrolling newline holds wr_ready low for COLS cycles.
  - clr holds wr_ready low for COLS*ROWS cycles.
- Reset mid-CLRLINE or mid-CLRALL: state restarts in CLRALL with a full clear; there is no partial completion.

## Test plan
- Reset, wait 960 cycles: wr_ready=1; sweep all rd_col/rd_row → rd_char=6'h20 everywhere; cursor=(0,0).
- Write 'A' (0x41), then 'a' (0x61): (0,0)→6'h01, (1,0)→6'h01, cursor=(2,0); rd_char for (0,0) changes the cycle after the accept.
- Write 40 printable chars on row 0: cursor=(0,1), wr_ready stays 1. CR at (5,3) → cursor=(0,4).
- Fill to row 23 and send CR:
  - wr_ready low exactly 40 cycles.
  - Logical row 0 shows former row 1; row 23 is all 6'h20; cursor=(0,23).
- Assert clr together with wr_valid in IDLE: char not accepted, wr_ready low 960 cycles, screen blank, cursor=(0,0), top=0.
- Cursor blink and reset mid-operation:
  - With BLINK_DIV=4, read at the cursor position: cursor_hit toggles every 4 cycles.
  - Reading (40,0) or (0,24) returns 6'h20 with cursor_hit=0.
  - Pulse rst_n during CLRLINE: outputs return to reset values immediately and a fresh 960-cycle clear follows.
